apb_slave_regs: RTL and testbench

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs
Interface
REQ-001 Parameter ID_VALUE, default 32'hA5B0_0001, constant returned by ID register (offset 0x1C).
REQ-002 Parameter RST_VAL, default 32'h0000_0000, reset value of RW registers 0-5.
REQ-003 clk  input  1  sole clock, all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 psel  input  1  APB select from master.
REQ-006 penable  input  1  APB access-phase strobe.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  32  byte address.
REQ-009 pwdata  input  32  write data.
REQ-010 pstrb  input  4  write byte strobes, bit n enables pwdata[8n+7:8n].
REQ-011 prdata  output  32  read data, valid while pready=1 on a read.
REQ-012 pready  output  1  transfer completion.
REQ-013 pslverr  output  1  transfer error, meaningful only while pready=1.
Function
REQ-014 Register map: offsets 0x00-0x14 RW regs 0-5; 0x18 STATUS (RO); 0x1C ID (RO, ID_VALUE).
REQ-015 STATUS[15:0] = count of OK-completed transfers, wraps 0xFFFF->0x0000; STATUS[31:16] = count of errored transfers, saturates at 0xFFFF.
REQ-016 FSM states IDLE, ACCESS; IDLE->ACCESS on psel=1 & penable=0 (setup cycle); ACCESS->IDLE when pready=1 or psel=0.
REQ-017 On setup-cycle edge: latch paddr, pwrite, pwdata, pstrb; load prdata from read mux; compute error flag.
REQ-018 Error when paddr[31:5]!=0, paddr[1:0]!=0, or write to 0x18/0x1C.
REQ-019 Errored read: prdata=0; errored write: no register change.
REQ-020 Read of valid offset: prdata = register value sampled at setup edge.
REQ-021 pready = 1 only in ACCESS with wait counter 0 (zero-wait: first access cycle).
REQ-022 pslverr = latched error flag AND pready; 0 otherwise.
REQ-023 Write commits on the edge where ACCESS, penable=1, pready=1, no error; only strobed bytes update.
REQ-024 STATUS counters update on the same completion edge; a write targeting STATUS is counted as error.
REQ-025 Back-to-back: setup cycle immediately after completion accepted with no idle gap.
REQ-026 psel=0 while in ACCESS before completion: abort, no write, no counter update, return IDLE.
REQ-027 Illegal access (psel=1, penable=1 in IDLE): pready=1, pslverr=1 same cycle, no side effect, error counter incremented.
REQ-028 Latched address/data held stable internally; master changes of paddr/pwdata during ACCESS ignored.
Reset
REQ-029 rst=1 asynchronously forces: state IDLE, prdata=0, pready=0, pslverr=0, regs 0-5 = RST_VAL, STATUS=0, wait counter=0.
REQ-030 Reset during ACCESS discards the transfer; no partial write.
REQ-031 First setup cycle accepted on first clk edge after rst falls.
Configuration
REQ-032 Macro APB_SLAVE_WAIT_EN.
REQ-033 Defined: wait counter loaded at setup edge with reg5[3:0]; ACCESS holds pready=0 for that many cycles, decrementing each cycle, then pready=1.
REQ-034 Defined: reg5[3:0]=0 gives zero-wait; prdata/pslverr stable throughout wait cycles.
REQ-035 Not defined: no wait counter logic; pready=1 in first ACCESS cycle always; reg5 is a plain RW register.
Verification
REQ-036 Write 0x00 data 0xDEADBEEF pstrb 4'hF, read 0x00 -> prdata 0xDEADBEEF, pslverr 0, STATUS[15:0]=2.
REQ-037 reg1=0x11223344, write 0x04 data 0xAABBCCDD pstrb 4'b0101 -> read 0x04 = 0x11BB33DD.
REQ-038 Write 0x1C, read 0x40, read 0x02 -> each pslverr=1, prdata 0 on reads, ID unchanged, STATUS[31:16]=3.
REQ-039 With APB_SLAVE_WAIT_EN, reg5=0x3, read 0x1C -> pready low 3 ACCESS cycles, high on 4th, prdata=ID_VALUE.
REQ-040 Assert rst during waited write to 0x08 -> pready 0 immediately, reg2 reads RST_VAL after reset.
REQ-041 psel=1,penable=1 from IDLE -> same-cycle pready=1, pslverr=1, no register change.

---
 rtl/apb_slave_regs.sv | 135 +++++++++++++
 tb/tb_apb_slave_regs.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/apb_slave_regs.sv
// APB slave with six RW registers, a transfer STATUS counter pair and a read-only ID word.
// Optional wait states come from reg5[3:0] when APB_SLAVE_WAIT_EN is defined.
module apb_slave_regs #(
  parameter logic [31:0] ID_VALUE = 32'hA5B0_0001,
  parameter logic [31:0] RST_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [31:0] regs [0:5];
  logic [15:0] ok_cnt, err_cnt;
  logic [2:0]  idx_q;
  logic        wr_q, err_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        setup, illegal, done, addr_err, wait_zero;
  logic [31:0] rd_mux;

  assign addr_err = (|paddr[31:5]) || (|paddr[1:0]) || (pwrite && paddr[4:3] == 2'b11);

  always_comb begin
    rd_mux = 32'h0;
    for (int i = 0; i < 6; i++)
      if (paddr[4:2] == 3'(i)) rd_mux = regs[i];
    if (paddr[4:2] == 3'd6) rd_mux = {err_cnt, ok_cnt};
    if (paddr[4:2] == 3'd7) rd_mux = ID_VALUE;
  end

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0] wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_q <= 4'd0;
    else if (setup)
      wait_q <= regs[5][3:0];
    else if (state_q == ACCESS && wait_q != 4'd0)
      wait_q <= wait_q - 4'd1;
  end

  assign wait_zero = (wait_q == 4'd0);
`else
  assign wait_zero = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    setup   = 1'b0;
    illegal = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          setup   = 1'b1;
          state_d = ACCESS;
        end else if (psel && penable) begin
          // Access phase without a setup phase: fail it on the spot
          illegal = 1'b1;
          pready  = 1'b1;
          pslverr = 1'b1;
        end
      end
      ACCESS: begin
        pready  = wait_zero;
        pslverr = wait_zero && err_q;
        if (wait_zero || !psel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      pready  = 1'b0;
      pslverr = 1'b0;
    end
  end

  assign done = (state_q == ACCESS) && psel && penable && pready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 3'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      prdata  <= 32'h0;
    end else if (setup) begin
      idx_q   <= paddr[4:2];
      wr_q    <= pwrite;
      err_q   <= addr_err;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      prdata  <= addr_err ? 32'h0 : rd_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) regs[i] <= RST_VAL;
      ok_cnt  <= 16'h0;
      err_cnt <= 16'h0;
    end else begin
      if (done && !err_q) begin
        ok_cnt <= ok_cnt + 16'd1;
        // err_q is clear, so idx_q is one of the RW registers on a write
        if (wr_q)
          for (int i = 0; i < 6; i++)
            if (idx_q == 3'(i))
              for (int b = 0; b < 4; b++)
                if (strb_q[b]) regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
      end
      if (((done && err_q) || illegal) && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: register map, strobes, errors, abort, illegal access, reset.
module tb_apb_slave_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = 32'h0, pwdata = 32'h0;
  logic [3:0]  pstrb = 4'h0;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] rd;
  logic        er;
  int          wt;

  apb_slave_regs dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transfer; paddr/pwdata are scrambled during ACCESS to prove they are latched
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] d, output logic e, output int w);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = s;
    @(negedge clk);
    penable = 1'b1; paddr = 32'hFFFF_FFFF; pwdata = ~wd;
    #1;
    w = 0;
    while (!pready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!pready) check("timeout", 32'(pready), 32'h1);
    d = prdata;
    e = pslverr;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s, input logic exp_err);
    xfer(1'b1, a, wd, s, rd, er, wt);
    check($sformatf("wr_err_%h", a), 32'(er), 32'(exp_err));
  endtask

  task automatic rd_reg(input logic [31:0] a, input logic [31:0] exp_d, input logic exp_err);
    xfer(1'b0, a, 32'h0, 4'h0, rd, er, wt);
    check($sformatf("rd_data_%h", a), rd, exp_d);
    check($sformatf("rd_err_%h", a), 32'(er), 32'(exp_err));
  endtask

  // Setup a write, then in the first ACCESS cycle either drop psel (abort) or assert reset
  task automatic start_write(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd; pstrb = 4'hF;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_prdata", prdata, 32'h0);
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    rd_reg(32'h18, 32'h0000_0000, 1'b0);
    xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, wt);
    check("rd0_rstval", rd, 32'h0);
    check("zero_wait", 32'(wt), 32'd0);
    wr_reg(32'h00, 32'hDEAD_BEEF, 4'hF, 1'b0);
    rd_reg(32'h00, 32'hDEAD_BEEF, 1'b0);
    rd_reg(32'h18, 32'h0000_0004, 1'b0);

    wr_reg(32'h04, 32'h1122_3344, 4'hF, 1'b0);
    wr_reg(32'h04, 32'hAABB_CCDD, 4'b0101, 1'b0);
    rd_reg(32'h04, 32'h11BB_33DD, 1'b0);

    wr_reg(32'h1C, 32'h1234_5678, 4'hF, 1'b1);
    rd_reg(32'h40, 32'h0, 1'b1);
    rd_reg(32'h02, 32'h0, 1'b1);
    rd_reg(32'h1C, 32'hA5B0_0001, 1'b0);
    rd_reg(32'h18, 32'h0003_0009, 1'b0);

    wr_reg(32'h18, 32'hFFFF_FFFF, 4'hF, 1'b1);
    rd_reg(32'h10, 32'h0, 1'b0);

    // Access phase straight from IDLE
    @(negedge clk);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h0; pstrb = 4'hF;
    #1;
    check("illegal_pready", 32'(pready), 32'h1);
    check("illegal_pslverr", 32'(pslverr), 32'h1);
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
    rd_reg(32'h18, 32'h0005_000B, 1'b0);
    rd_reg(32'h00, 32'hDEAD_BEEF, 1'b0);

    // Abort: psel dropped in ACCESS
    start_write(32'h08, 32'h1234_5678);
    psel = 1'b0;
    rd_reg(32'h08, 32'h0, 1'b0);
    rd_reg(32'h18, 32'h0005_000E, 1'b0);

    // Reset in the ACCESS cycle of a write
    start_write(32'h08, 32'hCAFE_F00D);
    penable = 1'b1;
    #1;
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    #1;
    check("rst_mid_pready", 32'(pready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_reg(32'h08, 32'h0, 1'b0);
    rd_reg(32'h00, 32'h0, 1'b0);
    rd_reg(32'h18, 32'h0000_0002, 1'b0);

`ifdef APB_SLAVE_WAIT_EN
    wr_reg(32'h14, 32'h0000_0003, 4'hF, 1'b0);
    xfer(1'b0, 32'h1C, 32'h0, 4'h0, rd, er, wt);
    check("wait_cycles", 32'(wt), 32'd3);
    check("wait_id", rd, 32'hA5B0_0001);
    check("wait_err", 32'(er), 32'h0);
    start_write(32'h08, 32'h5555_AAAA);
    penable = 1'b1;
    #1;
    check("wait_pready_low", 32'(pready), 32'h0);
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    #1;
    check("wait_rst_pready", 32'(pready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_reg(32'h08, 32'h0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
